// File: rtl/simple_processor_pkg.sv
// Shared definitions for the multi-cycle bus processor: opcodes, FSM states,
// ALU operations and bus source selection.
package simple_processor_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MVI  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MVNZ = 3'b111;

    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;

    typedef enum logic [1:0] {BUS_NONE, BUS_REG, BUS_DIN, BUS_G} bus_sel_t;

    // Only meaningful for the five ALU opcodes; anything else maps to add.
    function automatic alu_op_t decode_alu(input logic [2:0] opcode);
        case (opcode)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/simple_processor_alu.sv
// Combinational ALU: modulo-2^DW add/sub plus bitwise logic, with zero detect.
module simple_processor_alu
    import simple_processor_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       op,
    output logic [DW-1:0] result,
    output logic          zero
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a + ~b + DW'(1);
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/simple_processor_param.sv
// Multi-cycle processor core: register file, A/G/IR registers, control FSM and
// the mux-driven shared bus. One instruction executes at a time.
module simple_processor_param
    import simple_processor_pkg::*;
#(
    parameter int DW    = 9,
    parameter int NREGS = 8,
    localparam int RW   = $clog2(NREGS)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    input  logic [RW-1:0] Dbg_sel,
    output logic [DW-1:0] Bus,
    output logic          Done,
    output logic          Zflag,
    output logic [DW-1:0] Dbg_data
);

    state_t        state, next_state;
    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] ir, a_reg, g_reg;

    logic [2:0]    opcode;
    logic [RW-1:0] x, y;

    bus_sel_t      bus_sel;
    logic [RW-1:0] bus_reg;
    logic          ir_load, a_load, g_load, rx_write;

    logic [DW-1:0] alu_result;
    logic          alu_zero;

    assign opcode = ir[DW-1 -: 3];
    assign x      = ir[DW-4 -: RW];
    assign y      = ir[DW-4-RW -: RW];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= T0;
        // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            T0: if (Run) next_state = T1;
            T1: if (opcode != OP_MV && opcode != OP_MVI && opcode != OP_MVNZ) next_state = T2;
                else next_state = T0;
            T2: next_state = T3;
            T3: next_state = T0;
            default: next_state = T0;
        endcase
    end

    // Control decode: bus source, register enables and Done.
    always_comb begin
        bus_sel  = BUS_NONE;
        bus_reg  = x;
        ir_load  = 1'b0;
        a_load   = 1'b0;
        g_load   = 1'b0;
        rx_write = 1'b0;
        Done     = 1'b0;
        case (state)
            T0: ir_load = Run;
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel  = BUS_REG;
                        bus_reg  = y;
                        rx_write = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel  = BUS_DIN;
                        rx_write = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVNZ: begin
                        bus_sel  = BUS_REG;
                        bus_reg  = y;
                        rx_write = ~Zflag;
                        Done     = 1'b1;
                    end
                    default: begin
                        bus_sel = BUS_REG;
                        bus_reg = x;
                        a_load  = 1'b1;
                    end
                endcase
            end
            T2: begin
                bus_sel = BUS_REG;
                bus_reg = y;
                g_load  = 1'b1;
            end
            T3: begin
                bus_sel  = BUS_G;
                rx_write = 1'b1;
                Done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus_sel)
            BUS_REG: Bus = regs[bus_reg];
            BUS_DIN: Bus = DIN;
            BUS_G:   Bus = g_reg;
            default: Bus = '0;
        endcase
    end

    simple_processor_alu #(.DW(DW)) u_alu (
        .a      (a_reg),
        .b      (Bus),
        .op     (decode_alu(opcode)),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            // NOTE: the register file is a handful of flops, so it is reset explicitly rather than left as RAM.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            ir    <= '0;
            a_reg <= '0;
            g_reg <= '0;
            Zflag <= 1'b0;
        end else begin
            if (ir_load)  ir    <= DIN;
            if (a_load)   a_reg <= Bus;
            if (g_load) begin
                g_reg <= alu_result;
                Zflag <= alu_zero;
            end
            if (rx_write) regs[x] <= Bus;
        end
    end

    assign Dbg_data = regs[Dbg_sel];

endmodule

// File: tb/tb_simple_processor_param.sv
// Directed bench for simple_processor_param: default 9-bit/8-register core plus
// a 12-bit/16-register instance for the parameterisation and back-to-back checks.
module tb_simple_processor_param;
    import simple_processor_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [8:0]  DIN;
    logic [2:0]  Dbg_sel;
    logic [8:0]  Bus;
    logic        Done;
    logic        Zflag;
    logic [8:0]  Dbg_data;

    logic        run2;
    logic [11:0] din2;
    logic [3:0]  dbg_sel2;
    logic [11:0] bus2;
    logic        done2;
    logic        zflag2;
    logic [11:0] dbg2;

    int passed = 0;
    int total  = 0;

    always #5 Clock = ~Clock;

    simple_processor_param dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .Dbg_sel(Dbg_sel),
        .Bus(Bus), .Done(Done), .Zflag(Zflag), .Dbg_data(Dbg_data)
    );

    simple_processor_param #(.DW(12), .NREGS(16)) dut_wide (
        .Clock(Clock), .Reset(Reset), .Run(run2), .DIN(din2), .Dbg_sel(dbg_sel2),
        .Bus(bus2), .Done(done2), .Zflag(zflag2), .Dbg_data(dbg2)
    );

    function automatic logic [8:0] enc(input logic [2:0] op, input int rx, input int ry);
        return {op, 3'(rx), 3'(ry)};
    endfunction

    function automatic logic [11:0] enc12(input logic [2:0] op, input int rx, input int ry);
        return {op, 4'(rx), 4'(ry), 1'b0};
    endfunction

    // Enter just after a negedge with the core in T0; return just after the
    // negedge following the Done cycle. cycles counts fetch through Done,
    // or -1 if Done never appeared.
    task automatic run_instr(input logic [8:0] instr, input logic [8:0] imm,
                             output int cycles, output logic [8:0] bus_t1);
        cycles = 1;
        bus_t1 = 'x;
        Run = 1'b1;
        DIN = instr;
        @(posedge Clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            Run = 1'b0;
            DIN = imm;
            #1;
            cycles++;
            if (cycles == 2) bus_t1 = Bus;
            if (Done) begin
                @(posedge Clock);
                @(negedge Clock);
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic read_reg(input int idx, output logic [8:0] val);
        Dbg_sel = 3'(idx);
        #1;
        val = Dbg_data;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        Reset = 1'b1; Run = 1'b1; DIN = 9'h0FF; Dbg_sel = '0;
        run2 = 1'b0; din2 = '0; dbg_sel2 = '0;
        @(negedge Clock);
        #1;
        total++; if (Bus !== 9'h000) $display("FAIL reset_bus: got %h expected 000", Bus); else passed++;
        total++; if (Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Done); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL reset_zflag: got %b expected 0", Zflag); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'h000) $display("FAIL reset_r0: got %h expected 000", v); else passed++;
        @(negedge Clock);
        Reset = 1'b0;
        Run = 1'b0;
    endtask

    task automatic test_mvi();
        int c; logic [8:0] b, v;
        run_instr(9'b011_000_000, 9'h1CF, c, b);
        total++; if (c !== 2) $display("FAIL mvi_latency: got %0d expected 2", c); else passed++;
        total++; if (b !== 9'h1CF) $display("FAIL mvi_bus_t1: got %h expected 1cf", b); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'h1CF) $display("FAIL mvi_r0: got %h expected 1cf", v); else passed++;
        for (int i = 1; i < 8; i++) begin
            read_reg(i, v);
            total++; if (v !== 9'h000) $display("FAIL mvi_r%0d_clear: got %h expected 000", i, v); else passed++;
        end
    endtask

    task automatic test_mv();
        int c; logic [8:0] b, v;
        run_instr(9'b000_001_000, 9'h000, c, b);
        total++; if (c !== 2) $display("FAIL mv_latency: got %0d expected 2", c); else passed++;
        total++; if (b !== 9'h1CF) $display("FAIL mv_bus_t1: got %h expected 1cf", b); else passed++;
        read_reg(1, v);
        total++; if (v !== 9'h1CF) $display("FAIL mv_r1: got %h expected 1cf", v); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'h1CF) $display("FAIL mv_r0_kept: got %h expected 1cf", v); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL mv_zflag: got %b expected 0", Zflag); else passed++;
    endtask

    task automatic test_alu();
        int c; logic [8:0] b, v;
        run_instr(enc(OP_MVI, 0, 0), 9'd200, c, b);
        run_instr(enc(OP_MVI, 1, 0), 9'd100, c, b);
        run_instr(enc(OP_ADD, 0, 1), 9'h000, c, b);
        total++; if (c !== 4) $display("FAIL add_latency: got %0d expected 4", c); else passed++;
        total++; if (b !== 9'd200) $display("FAIL add_bus_t1: got %0d expected 200", b); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'd300) $display("FAIL add_r0: got %0d expected 300", v); else passed++;
        run_instr(enc(OP_SUB, 1, 0), 9'h000, c, b);
        read_reg(1, v);
        total++; if (v !== 9'd312) $display("FAIL sub_r1: got %0d expected 312", v); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL sub_zflag: got %b expected 0", Zflag); else passed++;
        run_instr(enc(OP_XOR, 2, 2), 9'h000, c, b);
        read_reg(2, v);
        total++; if (v !== 9'd0) $display("FAIL xor_r2: got %0d expected 0", v); else passed++;
        total++; if (Zflag !== 1'b1) $display("FAIL xor_zflag: got %b expected 1", Zflag); else passed++;
        run_instr(enc(OP_AND, 0, 1), 9'h000, c, b);
        read_reg(0, v);
        total++; if (v !== 9'd296) $display("FAIL and_r0: got %0d expected 296", v); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL and_zflag: got %b expected 0", Zflag); else passed++;
    endtask

    task automatic test_mvnz();
        int c; logic [8:0] b, v;
        run_instr(enc(OP_XOR, 2, 2), 9'h000, c, b);
        run_instr(enc(OP_MVNZ, 3, 0), 9'h000, c, b);
        total++; if (c !== 2) $display("FAIL mvnz_z1_done: got %0d cycles expected 2", c); else passed++;
        read_reg(3, v);
        total++; if (v !== 9'd0) $display("FAIL mvnz_z1_r3: got %0d expected 0", v); else passed++;
        total++; if (Zflag !== 1'b1) $display("FAIL mvnz_zflag_kept: got %b expected 1", Zflag); else passed++;
        run_instr(enc(OP_OR, 4, 0), 9'h000, c, b);
        read_reg(4, v);
        total++; if (v !== 9'd296) $display("FAIL or_r4: got %0d expected 296", v); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL or_zflag: got %b expected 0", Zflag); else passed++;
        run_instr(enc(OP_MVNZ, 3, 0), 9'h000, c, b);
        read_reg(3, v);
        total++; if (v !== 9'd296) $display("FAIL mvnz_z0_r3: got %0d expected 296", v); else passed++;
    endtask

    task automatic test_idle();
        logic [8:0] v;
        int bad = 0;
        Run = 1'b0;
        DIN = enc(OP_MVI, 5, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            #1;
            if (Done !== 1'b0 || Bus !== 9'h000) bad++;
        end
        total++; if (bad !== 0) $display("FAIL idle_outputs: got %0d active cycles expected 0", bad); else passed++;
        read_reg(5, v);
        total++; if (v !== 9'd0) $display("FAIL idle_r5: got %0d expected 0", v); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'd296) $display("FAIL idle_r0: got %0d expected 296", v); else passed++;
    endtask

    task automatic test_reset_mid();
        int c; logic [8:0] b, v;
        run_instr(enc(OP_XOR, 2, 2), 9'h000, c, b);
        Run = 1'b1;
        DIN = enc(OP_ADD, 0, 1);
        @(posedge Clock);
        @(negedge Clock);
        Run = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        #1;
        total++; if (Bus !== 9'd312) $display("FAIL rst_mid_t2_bus: got %0d expected 312", Bus); else passed++;
        Reset = 1'b1;
        #1;
        total++; if (Done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", Done); else passed++;
        total++; if (Bus !== 9'h000) $display("FAIL rst_mid_bus: got %h expected 000", Bus); else passed++;
        total++; if (Zflag !== 1'b0) $display("FAIL rst_mid_zflag: got %b expected 0", Zflag); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'd0) $display("FAIL rst_mid_r0: got %0d expected 0", v); else passed++;
        read_reg(4, v);
        total++; if (v !== 9'd0) $display("FAIL rst_mid_r4: got %0d expected 0", v); else passed++;
        @(negedge Clock);
        Reset = 1'b0;
        run_instr(enc(OP_MVI, 6, 0), 9'h055, c, b);
        total++; if (c !== 2) $display("FAIL post_rst_latency: got %0d expected 2", c); else passed++;
        read_reg(6, v);
        total++; if (v !== 9'h055) $display("FAIL post_rst_r6: got %h expected 055", v); else passed++;
        read_reg(0, v);
        total++; if (v !== 9'd0) $display("FAIL post_rst_r0: got %0d expected 0", v); else passed++;
    endtask

    task automatic test_back_to_back();
        run2 = 1'b1;
        din2 = enc12(OP_MVI, 15, 0);
        @(posedge Clock);
        @(negedge Clock);
        din2 = 12'hABC;
        #1;
        total++; if (done2 !== 1'b1) $display("FAIL b2b_mvi_done: got %b expected 1", done2); else passed++;
        total++; if (bus2 !== 12'hABC) $display("FAIL b2b_mvi_bus: got %h expected abc", bus2); else passed++;
        @(posedge Clock);
        @(negedge Clock);
        din2 = enc12(OP_MV, 0, 15);
        #1;
        total++; if (done2 !== 1'b0) $display("FAIL b2b_t0_done: got %b expected 0", done2); else passed++;
        @(posedge Clock);
        @(negedge Clock);
        run2 = 1'b0;
        #1;
        total++; if (done2 !== 1'b1) $display("FAIL b2b_mv_done: got %b expected 1", done2); else passed++;
        total++; if (bus2 !== 12'hABC) $display("FAIL b2b_mv_bus: got %h expected abc", bus2); else passed++;
        @(posedge Clock);
        @(negedge Clock);
        dbg_sel2 = 4'd0;
        #1;
        total++; if (dbg2 !== 12'hABC) $display("FAIL wide_r0: got %h expected abc", dbg2); else passed++;
        dbg_sel2 = 4'd15;
        #1;
        total++; if (dbg2 !== 12'hABC) $display("FAIL wide_r15: got %h expected abc", dbg2); else passed++;
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_mv();
        test_alu();
        test_mvnz();
        test_idle();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simple_processor_param.md
Name: simple_processor_param

Overview:
Parametrised next-generation multi-cycle processor core that executes one instruction at a time from the DIN port onto a shared Bus. Data width and register-file depth are parametrised. It extends the base instruction set (mv, mvi, add, sub) with logical ops, a zero flag and a conditional move. A register read-back port lets the bench check state without probing internals.

Parameters:
DW, 9, data/instruction width in bits; must satisfy DW >= 3 + 2*RW.
NREGS, 8, number of general registers R0..R(NREGS-1); power of two, 2..16.
RW, $clog2(NREGS), localparam, width of the register-select field.

Ports:
Clock  input  1  single system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Run  input  1  start request, sampled only in state T0.
DIN  input  DW  instruction word in T0; immediate data in mvi T1.
Dbg_sel  input  RW  register index for read-back.
Bus  output  DW  shared datapath bus, mux-driven.
Done  output  1  high during the final cycle of each instruction.
Zflag  output  1  zero flag from the last ALU result.
Dbg_data  output  DW  combinational value of R[Dbg_sel].

Behaviour:
- Instruction fields: IR[DW-1:DW-3]=opcode, next RW bits=X (destination), next RW bits=Y (source), remaining LSBs ignored.
- Opcodes: 000 mv, 001 add, 010 sub, 011 mvi, 100 and, 101 or, 110 xor, 111 mvnz.
- Reset (async): R*, A, G, IR cleared to 0; Zflag=0; FSM to T0; Done=0; Bus=0.
- FSM states: T0, T1, T2, T3.
- T0: if Run=1, IR<=DIN and go to T1; otherwise stay in T0 with no register change. Bus=0 and Done=0 in T0.
- mv, T1: Bus=RY, RX<=Bus, Done=1, next state T0. Latency is 2 cycles including fetch.
- mvi, T1: Bus=DIN, RX<=DIN, Done=1, next state T0.
- mvnz, T1: Bus=RY. RX<=Bus only if Zflag=0; otherwise RX is unchanged. Done=1 in both cases, next state T0.
- ALU ops (add, sub, and, or, xor):
  - T1: Bus=RX, A<=Bus.
  - T2: Bus=RY, G<=A op Bus, Zflag<=(result==0).
  - T3: Bus=G, RX<=G, Done=1, next state T0.
  - Latency is 4 cycles.
- Arithmetic is modulo 2^DW with no carry or overflow output. sub computes A + ~Bus + 1.
- Zflag changes only in T2 of ALU ops. mv, mvi and mvnz leave it unchanged.
- X==Y is legal. add R0,R0 doubles R0. xor Rx,Rx yields 0 and sets Zflag=1.
- Run may stay high continuously: the next instruction is fetched in the T0 immediately after Done.
- Run and DIN are ignored outside T0, except DIN in mvi T1.
- Done is a combinational decode of state and opcode. It is never high in T0.
- Bus defaults to 0 when no source is selected. Bus is never X after reset.
- Reset asserted mid-instruction aborts immediately. The partially computed G is not written back.
- Dbg_data reflects register writes the cycle after the write edge.

Decomposition:
- Package simple_processor_pkg holds:
  - opcode localparams (OP_MV..OP_MVNZ);
  - state encoding typedef (T0..T3);
  - ALU-op enum.
- One sub-module, simple_processor_alu: combinational, parametrised by DW. Inputs A, B, op. Outputs result and zero.
- Register file, control FSM and bus mux stay in the top module.

Test Plan:
1. Reset, Run=1, DIN=9'b011_000_000 then 9'h1CF -> Done high in 2nd cycle, Bus=9'h1CF during T1, Dbg R0=9'h1CF, R1..R7=0.
2. mv R1,R0 (9'b000_001_000) after test 1 -> R1=9'h1CF after 2 cycles, R0 unchanged, Zflag unchanged.
3. ALU sequence:
   - R0=200, R1=100; add R0,R1 -> R0=300, Done in 4th cycle.
   - sub R1,R0 -> R1=9'd312 (100-300 mod 512), Zflag=0.
   - xor R2,R2 -> R2=0, Zflag=1.
   - and R0,R1 -> R0=300&312=9'd296.
4. mvnz:
   - With Zflag=1, mvnz R3,R0 -> R3 stays 0, Done still pulses.
   - Then or R4,R0 (R4=0, result nonzero) -> Zflag=0; mvnz R3,R0 -> R3=R0.
5. Control edge cases:
   - Run=0 for 5 cycles with a valid DIN -> FSM stays T0, Done=0, registers unchanged.
   - Reset asserted during T2 of an add -> all registers 0, Zflag=0, Done=0 immediately.
   - Reset deasserted with Run=1 -> next instruction fetched cleanly.
6. Instance with DW=12, NREGS=16: mvi R15,12'hABC then mv R0,R15 -> Dbg R0=12'hABC. Back-to-back instructions with Run held high show no idle cycle between Done and the next fetch.
